// File: rtl/backup_mem_ctrl.sv
// backup_mem_ctrl: backing-store memory model for the MIF port, used behind
// the uncore in place of DRAM. Requests are queued in a small FIFO and then
// served in order as DATA_CYCLES-beat read or write bursts against an internal
// array. The array is built as one byte-wide lane per data byte.
//
// Optional feature: define BACKUP_MEM_WMASK_EN to add the mem_req_data_mask
// byte-enable port. Without it, every write beat writes the whole word.
module backup_mem_ctrl #(
  parameter int DATA_BITS      = 64,
  parameter int ADDR_BITS      = 26,
  parameter int TAG_BITS       = 5,
  parameter int DATA_CYCLES    = 8,
  parameter int DEPTH_BEATS    = 2097152,
  parameter int REQ_FIFO_DEPTH = 2
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   mem_req_valid,
  output logic                   mem_req_ready,
  input  logic                   mem_req_rw,
  input  logic [ADDR_BITS-1:0]   mem_req_addr,
  input  logic [TAG_BITS-1:0]    mem_req_tag,
  input  logic                   mem_req_data_valid,
  output logic                   mem_req_data_ready,
  input  logic [DATA_BITS-1:0]   mem_req_data_bits,
`ifdef BACKUP_MEM_WMASK_EN
  input  logic [DATA_BITS/8-1:0] mem_req_data_mask,
`endif
  output logic                   mem_resp_valid,
  input  logic                   mem_resp_ready,
  output logic [DATA_BITS-1:0]   mem_resp_data,
  output logic [TAG_BITS-1:0]    mem_resp_tag
);

  // Derived sizes. A beat index is the burst address (low bits) followed by
  // the beat counter.
  localparam int BYTES          = DATA_BITS / 8;
  localparam int CNT_BITS       = $clog2(DATA_CYCLES);
  localparam int BURST_IDX_BITS = $clog2(DEPTH_BEATS / DATA_CYCLES);
  localparam int IDX_BITS       = BURST_IDX_BITS + CNT_BITS;
  localparam int PTR_BITS       = (REQ_FIFO_DEPTH > 1) ? $clog2(REQ_FIFO_DEPTH) : 1;
  localparam int FILL_BITS      = $clog2(REQ_FIFO_DEPTH + 1);
  localparam int ENTRY_BITS     = 1 + BURST_IDX_BITS + TAG_BITS;

  localparam logic [CNT_BITS-1:0]  CNT_LAST  = CNT_BITS'(DATA_CYCLES - 1);
  localparam logic [FILL_BITS-1:0] FILL_FULL = FILL_BITS'(REQ_FIFO_DEPTH);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    WRITE = 2'd2
  } state_t;

  // ---------------------------------------------------------------------------
  // Request queue
  // ---------------------------------------------------------------------------
  logic [ENTRY_BITS-1:0] q_mem [REQ_FIFO_DEPTH];
  logic [PTR_BITS-1:0]   q_wr_ptr_reg;
  logic [PTR_BITS-1:0]   q_rd_ptr_reg;
  logic [FILL_BITS-1:0]  q_fill_reg;
  logic                  q_full;
  logic                  q_empty;
  logic                  q_enq;
  logic                  q_deq;
  logic [ENTRY_BITS-1:0] q_head;
  logic                  head_rw;
  logic [BURST_IDX_BITS-1:0] head_addr;
  logic [TAG_BITS-1:0]   head_tag;

  // Pointer advance; a single-entry queue keeps its pointer at zero.
  function automatic logic [PTR_BITS-1:0] ptr_inc(input logic [PTR_BITS-1:0] p);
    if (REQ_FIFO_DEPTH == 1) begin
      return '0;
    end
    return p + PTR_BITS'(1);
  endfunction

  assign q_full  = (q_fill_reg == FILL_FULL);
  assign q_empty = (q_fill_reg == '0);

  // There is no bypass: a pop in the same cycle does not make room for a push.
  assign mem_req_ready = !q_full;
  assign q_enq         = mem_req_valid && !q_full;

  assign q_head    = q_mem[q_rd_ptr_reg];
  assign head_rw   = q_head[ENTRY_BITS-1];
  assign head_addr = q_head[TAG_BITS +: BURST_IDX_BITS];
  assign head_tag  = q_head[TAG_BITS-1:0];

  // Only the burst-index bits of the address are kept. Higher bits alias.
  generate
    if (ADDR_BITS > BURST_IDX_BITS) begin : g_addr_alias
      logic unused_addr_hi;
      assign unused_addr_hi = ^mem_req_addr[ADDR_BITS-1:BURST_IDX_BITS];
    end
  endgenerate

  // Queue storage. Entries need no reset because the fill count guards them.
  always_ff @(posedge clk) begin
    if (q_enq) begin
      q_mem[q_wr_ptr_reg] <= {mem_req_rw, mem_req_addr[BURST_IDX_BITS-1:0], mem_req_tag};
    end
  end

  // Queue pointers and occupancy.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      q_wr_ptr_reg <= '0;
      q_rd_ptr_reg <= '0;
      q_fill_reg   <= '0;
    end else begin
      if (q_enq) begin
        q_wr_ptr_reg <= ptr_inc(q_wr_ptr_reg);
      end
      if (q_deq) begin
        q_rd_ptr_reg <= ptr_inc(q_rd_ptr_reg);
      end
      case ({q_enq, q_deq})
        2'b10:   q_fill_reg <= q_fill_reg + FILL_BITS'(1);
        2'b01:   q_fill_reg <= q_fill_reg - FILL_BITS'(1);
        default: q_fill_reg <= q_fill_reg;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Burst engine
  // ---------------------------------------------------------------------------
  state_t                    state_reg, state_next;
  logic [CNT_BITS-1:0]       cnt_reg, cnt_next;
  logic [BURST_IDX_BITS-1:0] cur_addr_reg, cur_addr_next;
  logic [TAG_BITS-1:0]       cur_tag_reg, cur_tag_next;
  logic                      resp_valid_reg;
  logic [TAG_BITS-1:0]       resp_tag_reg;
  logic                      rd_issue;
  logic                      wr_fire;
  logic                      wr_ready;
  logic                      load_head;
  logic [IDX_BITS-1:0]       beat_idx;

  assign beat_idx = {cur_addr_reg, cnt_reg};

  // Engine state register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg    <= IDLE;
      cnt_reg      <= '0;
      cur_addr_reg <= '0;
      cur_tag_reg  <= '0;
    end else begin
      state_reg    <= state_next;
      cnt_reg      <= cnt_next;
      cur_addr_reg <= cur_addr_next;
      cur_tag_reg  <= cur_tag_next;
    end
  end

  // Next-state logic. A burst ends on its last beat. At that edge the next
  // request, if one is queued, is loaded straight away so there is no idle
  // cycle between bursts.
  always_comb begin
    state_next    = state_reg;
    cnt_next      = cnt_reg;
    cur_addr_next = cur_addr_reg;
    cur_tag_next  = cur_tag_reg;
    load_head     = 1'b0;
    rd_issue      = 1'b0;
    wr_fire       = 1'b0;
    wr_ready      = 1'b0;

    case (state_reg)
      IDLE: begin
        load_head = !q_empty;
      end
      READ: begin
        // Issue a beat only into an empty or draining response register.
        rd_issue = !resp_valid_reg || mem_resp_ready;
      end
      WRITE: begin
        wr_ready = 1'b1;
        wr_fire  = mem_req_data_valid;
      end
      default: begin
        state_next = IDLE;
      end
    endcase

    if (rd_issue || wr_fire) begin
      cnt_next = cnt_reg + CNT_BITS'(1);
      if (cnt_reg == CNT_LAST) begin
        if (!q_empty) begin
          load_head = 1'b1;
        end else begin
          state_next = IDLE;
        end
      end
    end

    if (load_head) begin
      state_next    = head_rw ? WRITE : READ;
      cur_addr_next = head_addr;
      cur_tag_next  = head_tag;
      cnt_next      = '0;
    end

    q_deq = load_head;
  end

  assign mem_req_data_ready = wr_ready;

  // Response handshake. Data and tag are loaded only when a beat is issued,
  // so they stay stable while the consumer stalls.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      resp_valid_reg <= 1'b0;
      resp_tag_reg   <= '0;
    end else if (rd_issue) begin
      resp_valid_reg <= 1'b1;
      resp_tag_reg   <= cur_tag_reg;
    end else if (mem_resp_ready) begin
      resp_valid_reg <= 1'b0;
    end
  end

  assign mem_resp_valid = resp_valid_reg;
  assign mem_resp_tag   = resp_tag_reg;

  // ---------------------------------------------------------------------------
  // Storage array: one byte lane per data byte, registered read
  // ---------------------------------------------------------------------------
  logic [BYTES-1:0] lane_en;

`ifdef BACKUP_MEM_WMASK_EN
  assign lane_en = mem_req_data_mask;
`else
  assign lane_en = '1;
`endif

  generate
    for (genvar gi = 0; gi < BYTES; gi++) begin : g_lane
      logic [7:0] lane_mem [DEPTH_BEATS];
      logic [7:0] lane_rd_reg;

      // Byte write on a data handshake when this lane is enabled.
      always_ff @(posedge clk) begin
        if (wr_fire && lane_en[gi]) begin
          lane_mem[beat_idx] <= mem_req_data_bits[gi*8 +: 8];
        end
      end

      // Registered read into this lane's slice of the response data.
      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
          lane_rd_reg <= '0;
        end else if (rd_issue) begin
          lane_rd_reg <= lane_mem[beat_idx];
        end
      end

      assign mem_resp_data[gi*8 +: 8] = lane_rd_reg;
    end
  endgenerate

endmodule

// File: tb/tb_backup_mem_ctrl.sv
// tb_backup_mem_ctrl: randomized and directed bench for backup_mem_ctrl.
// The reference is a transaction-level model: an ordered list of requests
// applied to a sparse memory. Each read request's expected beats are computed
// when that request is accepted. Because the engine serves requests strictly
// in order, this gives the correct data.
// The macro BACKUP_MEM_WMASK_EN selects the byte-mask build.
module tb_backup_mem_ctrl;

  localparam int DW     = 64;
  localparam int AW     = 26;
  localparam int TW     = 5;
  localparam int DC     = 8;
  localparam int DEPTH  = 2097152;
  localparam int QD     = 2;
  localparam int BURSTS = DEPTH / DC;

  logic          clk;
  logic          reset_n;
  logic          mem_req_valid;
  logic          mem_req_ready;
  logic          mem_req_rw;
  logic [AW-1:0] mem_req_addr;
  logic [TW-1:0] mem_req_tag;
  logic          mem_req_data_valid;
  logic          mem_req_data_ready;
  logic [DW-1:0] mem_req_data_bits;
  logic [7:0]    mem_req_data_mask;
  logic          mem_resp_valid;
  logic          mem_resp_ready;
  logic [DW-1:0] mem_resp_data;
  logic [TW-1:0] mem_resp_tag;

  backup_mem_ctrl #(
    .DATA_BITS(DW), .ADDR_BITS(AW), .TAG_BITS(TW), .DATA_CYCLES(DC),
    .DEPTH_BEATS(DEPTH), .REQ_FIFO_DEPTH(QD)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .mem_req_valid(mem_req_valid),
    .mem_req_ready(mem_req_ready),
    .mem_req_rw(mem_req_rw),
    .mem_req_addr(mem_req_addr),
    .mem_req_tag(mem_req_tag),
    .mem_req_data_valid(mem_req_data_valid),
    .mem_req_data_ready(mem_req_data_ready),
    .mem_req_data_bits(mem_req_data_bits),
`ifdef BACKUP_MEM_WMASK_EN
    .mem_req_data_mask(mem_req_data_mask),
`endif
    .mem_resp_valid(mem_resp_valid),
    .mem_resp_ready(mem_resp_ready),
    .mem_resp_data(mem_resp_data),
    .mem_resp_tag(mem_resp_tag)
  );

  typedef struct packed {
    logic               rw;
    logic [AW-1:0]      addr;
    logic [TW-1:0]      tag;
    logic [DC-1:0][63:0] data;
    logic [DC-1:0][7:0]  mask;
    logic [3:0]         nbeats;
  } req_t;

  typedef struct packed {
    logic [63:0]   data;
    logic [TW-1:0] tag;
  } exp_t;

  req_t        rq[$];
  logic [63:0] wq_data[$];
  logic [7:0]  wq_mask[$];
  exp_t        eq[$];
  logic [63:0] model_mem [int];

  int          checks = 0;
  int          failures = 0;
  int          cyc = 0;
  int          rdy_mode = 0;
  int          wbeats = 0;
  bit          data_gap = 0;

  int            beat_cyc[$];
  logic [63:0]   beat_data[$];
  logic [TW-1:0] beat_tag[$];
  int            acc_cyc_rd[$];

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    forever begin
      @(posedge clk);
      cyc++;
    end
  end

  initial begin
    #900000;
    $display("FAIL watchdog actual=still running required=finished");
    $fatal(1, "watchdog expired");
  end

  // Model address map: only the burst index (address modulo burst count) selects storage.
  function automatic int model_key(input logic [AW-1:0] a, input int beat);
    return int'(a % BURSTS) * DC + beat;
  endfunction

  function automatic logic [63:0] model_rd(input int key);
    if (model_mem.exists(key)) return model_mem[key];
    return '0;
  endfunction

  function automatic logic [63:0] merge(input logic [63:0] old, input logic [63:0] d,
                                        input logic [7:0] m);
    logic [63:0] r;
    r = old;
    for (int b = 0; b < 8; b++) begin
      if (m[b]) r[b*8 +: 8] = d[b*8 +: 8];
    end
    return r;
  endfunction

  task automatic check64(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=0x%h required=0x%h", name, act, req);
    end
  endtask

  task automatic push_req(input logic rw, input logic [AW-1:0] addr, input logic [TW-1:0] tag,
                          input logic [DC-1:0][63:0] data, input logic [DC-1:0][7:0] mask,
                          input int nb);
    req_t r;
    r.rw = rw;
    r.addr = addr;
    r.tag = tag;
    r.data = data;
    r.mask = mask;
    r.nbeats = 4'(nb);
    rq.push_back(r);
  endtask

  // Accepting a request applies its effect to the model in request order.
  task automatic accept_req(input req_t r);
    exp_t e;
    int key;
    $display("REQ cyc=%0d rw=%0d addr=0x%h tag=%0d", cyc + 1, r.rw, r.addr, r.tag);
    if (r.rw) begin
      for (int k = 0; k < int'(r.nbeats); k++) begin
        key = model_key(r.addr, k);
        model_mem[key] = merge(model_rd(key), r.data[k], r.mask[k]);
        wq_data.push_back(r.data[k]);
        wq_mask.push_back(r.mask[k]);
      end
    end else begin
      acc_cyc_rd.push_back(cyc + 1);
      for (int k = 0; k < DC; k++) begin
        e.data = model_rd(model_key(r.addr, k));
        e.tag = r.tag;
        eq.push_back(e);
      end
    end
  endtask

  // Single negedge process: compare responses, then drive every input for the next edge.
  initial begin
    bit rdy_n;
    mem_req_valid = 1'b0;
    mem_req_rw = 1'b0;
    mem_req_addr = '0;
    mem_req_tag = '0;
    mem_req_data_valid = 1'b0;
    mem_req_data_bits = '0;
    mem_req_data_mask = 8'hFF;
    mem_resp_ready = 1'b0;
    forever begin
      @(negedge clk);
      if (!reset_n) begin
        mem_req_valid = 1'b0;
        mem_req_data_valid = 1'b0;
      end else begin
        if (mem_resp_valid) begin
          if (eq.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL resp_unexpected actual=valid tag=%0d required=no beat", mem_resp_tag);
          end else begin
            check64("resp_data", mem_resp_data, eq[0].data);
            check64("resp_tag", 64'(mem_resp_tag), 64'(eq[0].tag));
          end
        end
        case (rdy_mode)
          0:       rdy_n = 1'b1;
          1:       rdy_n = !mem_resp_ready;
          2:       rdy_n = ($urandom_range(3) != 0);
          default: rdy_n = 1'b0;
        endcase
        mem_resp_ready = rdy_n;
        if (mem_resp_valid && rdy_n && eq.size() != 0) begin
          beat_cyc.push_back(cyc);
          beat_data.push_back(mem_resp_data);
          beat_tag.push_back(mem_resp_tag);
          eq.pop_front();
        end
        if (rq.size() != 0) begin
          mem_req_valid = 1'b1;
          mem_req_rw = rq[0].rw;
          mem_req_addr = rq[0].addr;
          mem_req_tag = rq[0].tag;
          if (mem_req_ready) begin
            accept_req(rq[0]);
            void'(rq.pop_front());
          end
        end else begin
          mem_req_valid = 1'b0;
        end
        if (wq_data.size() != 0 && (!data_gap || $urandom_range(3) != 0)) begin
          mem_req_data_valid = 1'b1;
          mem_req_data_bits = wq_data[0];
          mem_req_data_mask = wq_mask[0];
          if (mem_req_data_ready) begin
            void'(wq_data.pop_front());
            void'(wq_mask.pop_front());
            wbeats++;
          end
        end else begin
          mem_req_data_valid = 1'b0;
        end
      end
    end
  end

  task automatic wait_idle(input int bound);
    bit done;
    done = 0;
    for (int i = 0; i < bound && !done; i++) begin
      @(negedge clk);
      if (rq.size() == 0 && wq_data.size() == 0 && eq.size() == 0 &&
          !mem_resp_valid && !mem_req_data_ready) done = 1;
    end
    checks++;
    if (!done) begin
      failures++;
      $display("FAIL idle_timeout actual=rq%0d/wq%0d/eq%0d required=drained", rq.size(),
               wq_data.size(), eq.size());
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic clear_logs();
    beat_cyc.delete();
    beat_data.delete();
    beat_tag.delete();
    acc_cyc_rd.delete();
  endtask

  task automatic check_idle_outputs(input string pfx);
    check64({pfx, "_resp_valid"}, 64'(mem_resp_valid), 64'd0);
    check64({pfx, "_resp_data"}, mem_resp_data, 64'd0);
    check64({pfx, "_resp_tag"}, 64'(mem_resp_tag), 64'd0);
    check64({pfx, "_req_ready"}, 64'(mem_req_ready), 64'd1);
    check64({pfx, "_data_ready"}, 64'(mem_req_data_ready), 64'd0);
  endtask

  initial begin
    logic [DC-1:0][63:0] d;
    logic [DC-1:0][7:0]  mfull;
    logic [DC-1:0][7:0]  m;
    logic [AW-1:0]       pool[4];
    logic [AW-1:0]       a;
    logic [63:0]         old3;
    int                  base;
    bit                  hit;

    mfull = '1;
    pool[0] = AW'(26'h3);
    pool[1] = AW'(26'h5);
    pool[2] = AW'(26'h155);
    pool[3] = AW'(26'h3FFFF);

    reset_n = 1'b0;
    repeat (3) @(negedge clk);
    check_idle_outputs("reset");
    reset_n = 1'b1;
    @(negedge clk);
    check_idle_outputs("post_reset");

    // Write 0x10..0x17 to burst 3, then read it back and check the latency.
    for (int k = 0; k < DC; k++) d[k] = 64'h10 + 64'(k);
    push_req(1'b1, 26'h3, 5'd1, d, mfull, DC);
    wait_idle(200);
    clear_logs();
    push_req(1'b0, 26'h3, 5'd2, '0, mfull, DC);
    wait_idle(200);
    check64("t1_beats", 64'(beat_data.size()), 64'd8);
    for (int k = 0; k < DC; k++) begin
      check64("t1_data", beat_data[k], 64'h10 + 64'(k));
      check64("t1_tag", 64'(beat_tag[k]), 64'd2);
    end
    check64("t1_latency", 64'(beat_cyc[0] - acc_cyc_rd[0]), 64'd2);

    // Two back-to-back reads must give 16 consecutive beats.
    for (int k = 0; k < DC; k++) d[k] = {$urandom, $urandom};
    push_req(1'b1, 26'h5, 5'd3, d, mfull, DC);
    wait_idle(200);
    clear_logs();
    push_req(1'b0, 26'h3, 5'd4, '0, mfull, DC);
    push_req(1'b0, 26'h5, 5'd5, '0, mfull, DC);
    wait_idle(200);
    check64("t2_beats", 64'(beat_data.size()), 64'd16);
    check64("t2_span", 64'(beat_cyc[15] - beat_cyc[0]), 64'd15);
    check64("t2_tag_first", 64'(beat_tag[7]), 64'd4);
    check64("t2_tag_second", 64'(beat_tag[8]), 64'd5);
    check64("t2_data_b8", beat_data[8], d[0]);

    // Response ready toggling every cycle.
    rdy_mode = 1;
    clear_logs();
    push_req(1'b0, 26'h3, 5'd6, '0, mfull, DC);
    wait_idle(300);
    check64("t3_beats", 64'(beat_data.size()), 64'd8);
    check64("t3_data0", beat_data[0], 64'h10);
    check64("t3_data7", beat_data[7], 64'h17);

    // Fill the queue while the response channel is blocked.
    rdy_mode = 3;
    for (int k = 0; k < QD + 2; k++) push_req(1'b0, 26'h3, TW'(7 + k), '0, mfull, DC);
    repeat (12) @(negedge clk);
    check64("t4_req_ready_full", 64'(mem_req_ready), 64'd0);
    check64("t4_waiting", 64'(rq.size()), 64'd1);
    rdy_mode = 0;
    wait_idle(400);

    // Randomized traffic with aliasing upper address bits.
    rdy_mode = 2;
    data_gap = 1;
    for (int p = 2; p < 4; p++) begin
      for (int k = 0; k < DC; k++) d[k] = {$urandom, $urandom};
      push_req(1'b1, pool[p], 5'd0, d, mfull, DC);
    end
    for (int n = 0; n < 40; n++) begin
      a = pool[$urandom_range(3)] | (AW'($urandom_range(255)) << 18);
      for (int k = 0; k < DC; k++) begin
        d[k] = {$urandom, $urandom};
`ifdef BACKUP_MEM_WMASK_EN
        m[k] = 8'($urandom);
`else
        m[k] = 8'hFF;
`endif
      end
      push_req(1'($urandom_range(1)), a, TW'($urandom_range(31)), d, m, DC);
    end
    wait_idle(4000);
    rdy_mode = 0;
    data_gap = 0;

`ifdef BACKUP_MEM_WMASK_EN
    // Masked write over all-ones.
    for (int k = 0; k < DC; k++) d[k] = '1;
    push_req(1'b1, 26'h20, 5'd1, d, mfull, DC);
    for (int k = 0; k < DC; k++) begin
      d[k] = '0;
      m[k] = 8'h0F;
    end
    push_req(1'b1, 26'h20, 5'd1, d, m, DC);
    wait_idle(200);
    clear_logs();
    push_req(1'b0, 26'h20, 5'd13, '0, mfull, DC);
    wait_idle(200);
    for (int k = 0; k < DC; k++) check64("mask_data", beat_data[k], 64'hFFFFFFFF00000000);
`endif

    // Reset in the middle of a write burst, after three beats.
    old3 = model_rd(model_key(26'h3, 3));
    for (int k = 0; k < DC; k++) d[k] = 64'hA0 + 64'(k);
    base = wbeats;
    push_req(1'b1, 26'h3, 5'd11, d, mfull, 3);
    hit = 0;
    for (int i = 0; i < 100 && !hit; i++) begin
      @(posedge clk);
      if (wbeats - base >= 3) hit = 1;
    end
    checks++;
    if (!hit) begin
      failures++;
      $display("FAIL rst_write_timeout actual=%0d beats required=3", wbeats - base);
    end
    #2;
    reset_n = 1'b0;
    #1;
    check_idle_outputs("mid_reset");
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    clear_logs();
    push_req(1'b0, 26'h3, 5'd12, '0, mfull, DC);
    wait_idle(200);
    check64("rst_beats", 64'(beat_data.size()), 64'd8);
    check64("rst_data0", beat_data[0], 64'hA0);
    check64("rst_data2", beat_data[2], 64'hA2);
    check64("rst_data3_old", beat_data[3], old3);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
